// File: rtl/cmd_exec_if.sv
// Command, bank-memory and response signal bundle for cmd_exec_engine.
// The master modport is the engine side; the slave modport is the FIFO/RAM/sink side.
interface cmd_exec_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BANK_W    = 2,
  parameter int NUM_BANKS = 3,
  parameter int LEN_W     = 4
) ();
  logic                        cmd_valid;
  logic                        cmd_rd_en;
  logic [1:0]                  cmd_opcode;
  logic [ADDR_W-1:0]           cmd_addr;
  logic [DATA_W-1:0]           cmd_data;
  logic [LEN_W-1:0]            cmd_len;

  logic [ADDR_W-BANK_W-1:0]    mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [NUM_BANKS-1:0]        mem_we;
  logic [NUM_BANKS-1:0]        mem_re;
  logic [NUM_BANKS*DATA_W-1:0] mem_rdata;

  logic                        resp_valid;
  logic                        resp_ready;
  logic [DATA_W-1:0]           resp_data;
  logic                        resp_status;
  logic                        resp_last;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_addr, cmd_data, cmd_len, mem_rdata, resp_ready,
    output cmd_rd_en, mem_addr, mem_wdata, mem_we, mem_re,
           resp_valid, resp_data, resp_status, resp_last
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_addr, cmd_data, cmd_len, mem_rdata, resp_ready,
    input  cmd_rd_en, mem_addr, mem_wdata, mem_we, mem_re,
           resp_valid, resp_data, resp_status, resp_last
  );
endinterface

// File: rtl/cmd_exec_engine.sv
// Multi-bank command executor: pops commands, runs single/burst bank accesses,
// and returns per-beat read responses or a single write acknowledgement.
//
// state    | meaning
// IDLE     | waiting for a command; pops it when cmd_valid
// RD_ISSUE | read strobe on the selected bank for one cycle
// RD_WAIT  | counting down bank read latency, captures data at terminal count
// RD_RESP  | holding a read response until the sink takes it
// WR_BEAT  | one write beat per cycle, accumulating sticky bank error
// WR_ACK   | holding the single write acknowledgement until the sink takes it
module cmd_exec_engine #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BANK_W    = 2,
  parameter int NUM_BANKS = 3,
  parameter int LEN_W     = 4,
  parameter int READ_LAT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  cmd_exec_if.master   bus,
  output logic         busy
);
  localparam int IA_W  = ADDR_W - BANK_W;
  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_BEAT, WR_ACK} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  beats_left;
  logic [LAT_W-1:0]  lat_cnt;
  logic              err;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] rd_word;

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: BANK_W];
  endfunction

  function automatic logic bank_ok(input logic [ADDR_W-1:0] a);
    return int'(bank_of(a)) < NUM_BANKS;
  endfunction

  // Unpopulated banks yield an all-zero select, which suppresses the strobe.
  function automatic logic [NUM_BANKS-1:0] bank_sel(input logic [ADDR_W-1:0] a);
    logic [NUM_BANKS-1:0] s;
    s = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (int'(bank_of(a)) == b) s[b] = 1'b1;
    return s;
  endfunction

  assign next_addr = cur_addr + 1'b1;

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (int'(bank_of(cur_addr)) == b) rd_word = bus.mem_rdata[b*DATA_W +: DATA_W];
  end

  // Pop is suppressed during reset so a queued command survives for after release.
  assign bus.cmd_rd_en = rst && (state == IDLE) && bus.cmd_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cur_addr        <= '0;
      beats_left      <= '0;
      lat_cnt         <= '0;
      err             <= 1'b0;
      busy            <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_we      <= '0;
      bus.mem_re      <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_status <= 1'b0;
      bus.resp_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_addr     <= bus.cmd_addr;
            beats_left   <= bus.cmd_opcode[1] ? {1'b0, bus.cmd_len} + 1'b1 : CNT_W'(1);
            bus.mem_addr <= bus.cmd_addr[IA_W-1:0];
            busy         <= 1'b1;
            if (!bus.cmd_opcode[0]) begin
              state      <= RD_ISSUE;
              bus.mem_re <= bank_sel(bus.cmd_addr);
            end else begin
              state         <= WR_BEAT;
              bus.mem_we    <= bank_sel(bus.cmd_addr);
              bus.mem_wdata <= bus.cmd_data;
              err           <= !bank_ok(bus.cmd_addr);
            end
          end
        end
        RD_ISSUE: begin
          bus.mem_re <= '0;
          lat_cnt    <= LAT_W'(READ_LAT);
          state      <= RD_WAIT;
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            bus.resp_valid  <= 1'b1;
            bus.resp_data   <= rd_word;
            bus.resp_status <= !bank_ok(cur_addr);
            bus.resp_last   <= (beats_left == CNT_W'(1));
            state           <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid  <= 1'b0;
            bus.resp_data   <= '0;
            bus.resp_status <= 1'b0;
            bus.resp_last   <= 1'b0;
            if (beats_left > CNT_W'(1)) begin
              beats_left   <= beats_left - 1'b1;
              cur_addr     <= next_addr;
              bus.mem_addr <= next_addr[IA_W-1:0];
              bus.mem_re   <= bank_sel(next_addr);
              state        <= RD_ISSUE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        WR_BEAT: begin
          if (beats_left > CNT_W'(1)) begin
            beats_left   <= beats_left - 1'b1;
            cur_addr     <= next_addr;
            bus.mem_addr <= next_addr[IA_W-1:0];
            bus.mem_we   <= bank_sel(next_addr);
            err          <= err | !bank_ok(next_addr);
          end else begin
            bus.mem_we      <= '0;
            bus.mem_wdata   <= '0;
            bus.resp_valid  <= 1'b1;
            bus.resp_last   <= 1'b1;
            bus.resp_data   <= '0;
            bus.resp_status <= err;
            state           <= WR_ACK;
          end
        end
        WR_ACK: begin
          if (bus.resp_ready) begin
            bus.resp_valid  <= 1'b0;
            bus.resp_status <= 1'b0;
            bus.resp_last   <= 1'b0;
            err             <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
